// File: rtl/sd_dma_pkg.sv
// Shared types and constants for the SD sector-buffer Wishbone DMA engine.
// One block is 512 bytes = 128 words of 32 bits.
package sd_dma_pkg;

  localparam int              BLOCK_SHIFT = 9;
  localparam int              WORD_BITS   = 7;
  localparam logic [WORD_BITS-1:0] WORD_LAST = 7'd127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_GO,
    S_RD_REL,
    S_WR_FETCH,
    S_WR_REQ,
    S_WR_DONE
  } state_t;

  // Byte address of one word of a block in system memory; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0]          base,
                                            input logic [31:0]          blk,
                                            input logic [WORD_BITS-1:0] word);
    return base + (blk << BLOCK_SHIFT) + {23'd0, word, 2'b00};
  endfunction

endpackage

// File: rtl/sd_wb_xfer.sv
// Single-word Wishbone B3 classic access with a no-response timeout.
// done/error/rdata are combinational and valid only in the completing cycle.
module sd_wb_xfer #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic        cyc,
  output logic        stb,
  output logic        bus_we,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat,
  input  logic [31:0] bus_dat_i,
  input  logic        ack,
  input  logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt;
  logic          expired;

  // The counter is loaded with TIMEOUT-1 when stb rises, so it reaches zero
  // in the TIMEOUT-th cycle with stb high and the access is dropped at that edge.
  assign expired = stb && (tmo_cnt == '0);
  assign done    = stb && (ack || err || expired);
  assign error   = stb && (err || (!ack && expired));
  assign rdata   = bus_dat_i;
  assign cyc     = stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb     <= 1'b0;
      bus_we  <= 1'b0;
      bus_adr <= '0;
      bus_dat <= '0;
      tmo_cnt <= '0;
    end else if (done) begin
      // NOTE: non-blocking assignments keep every register here sampling the
      // pre-edge value of done/stb, independent of statement order.
      stb <= 1'b0;
    end else if (start && !stb) begin
      stb     <= 1'b1;
      bus_we  <= we;
      bus_adr <= adr;
      bus_dat <= dat;
      tmo_cnt <= CW'(TIMEOUT - 1);
    end else if (stb) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/sd_wb_dma.sv
// Wishbone-master DMA between the SD buffer manager's BRAM ext ports and
// system memory: fills the read buffer or drains the write buffer, one block per request.
module sd_wb_dma
  import sd_dma_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic [31:0] cfg_base,
  input  logic        ext_read_act,
  input  logic [31:0] ext_read_addr,
  input  logic        ext_read_stop,
  output logic        ext_read_go,
  input  logic        ext_write_act,
  input  logic [31:0] ext_write_addr,
  output logic        ext_write_done,
  output logic [6:0]  bram_rd_ext_addr,
  output logic        bram_rd_ext_wren,
  output logic [31:0] bram_rd_ext_data,
  output logic [6:0]  bram_wr_ext_addr,
  input  logic [31:0] bram_wr_ext_q,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        dma_err
);

  logic [1:0] rd_act_sync, rd_stop_sync, wr_act_sync;
  logic       act_r, stop_s, act_w;

  state_t                 state;
  logic [31:0]            block;
  logic [WORD_BITS-1:0]   word;
  logic                   rd_next;
  logic                   wr_first;

  logic        xfer_start, xfer_we, xfer_done, xfer_error;
  logic [31:0] xfer_adr, xfer_dat, xfer_rdata;

  assign wbm_sel_o = 4'hF;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      rd_act_sync  <= '0;
      rd_stop_sync <= '0;
      wr_act_sync  <= '0;
    end else begin
      rd_act_sync  <= {rd_act_sync[0], ext_read_act};
      rd_stop_sync <= {rd_stop_sync[0], ext_read_stop};
      wr_act_sync  <= {wr_act_sync[0], ext_write_act};
    end
  end

  assign act_r  = rd_act_sync[1];
  assign stop_s = rd_stop_sync[1];
  assign act_w  = wr_act_sync[1];

  // A read issues its first access on the IDLE exit edge, before the block
  // number is latched, so the address comes straight from ext_read_addr there.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    xfer_start = 1'b0;
    xfer_adr   = word_addr(cfg_base, block, word);
    xfer_we    = (state == S_WR_REQ);
    xfer_dat   = xfer_we ? bram_wr_ext_q : '0;
    unique case (state)
      S_IDLE: begin
        xfer_start = !act_w && act_r;
        xfer_adr   = word_addr(cfg_base, ext_read_addr, '0);
      end
      S_RD_REQ: xfer_start = rd_next;
      S_WR_REQ: xfer_start = wr_first;
      default:  xfer_start = 1'b0;
    endcase
  end

  sd_wb_xfer #(
    .TIMEOUT (TIMEOUT)
  ) u_xfer (
    .clk       (clk_50),
    .rst_n     (reset_n),
    .start     (xfer_start),
    .we        (xfer_we),
    .adr       (xfer_adr),
    .dat       (xfer_dat),
    .done      (xfer_done),
    .error     (xfer_error),
    .rdata     (xfer_rdata),
    .cyc       (wbm_cyc_o),
    .stb       (wbm_stb_o),
    .bus_we    (wbm_we_o),
    .bus_adr   (wbm_adr_o),
    .bus_dat   (wbm_dat_o),
    .bus_dat_i (wbm_dat_i),
    .ack       (wbm_ack_i),
    .err       (wbm_err_i)
  );

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      block            <= '0;
      word             <= '0;
      rd_next          <= 1'b0;
      wr_first         <= 1'b0;
      bram_rd_ext_wren <= 1'b0;
      bram_rd_ext_addr <= '0;
      bram_rd_ext_data <= '0;
      bram_wr_ext_addr <= '0;
      ext_read_go      <= 1'b0;
      ext_write_done   <= 1'b0;
      dma_err          <= 1'b0;
    end else begin
      bram_rd_ext_wren <= 1'b0;
      rd_next          <= 1'b0;
      wr_first         <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (act_w) begin
            block            <= ext_write_addr;
            word             <= '0;
            bram_wr_ext_addr <= '0;
            dma_err          <= 1'b0;
            state            <= S_WR_FETCH;
          end else if (act_r) begin
            block   <= ext_read_addr;
            word    <= '0;
            dma_err <= 1'b0;
            state   <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (xfer_done) begin
            bram_rd_ext_wren <= 1'b1;
            bram_rd_ext_addr <= word;
            bram_rd_ext_data <= xfer_error ? '0 : xfer_rdata;
            if (xfer_error) dma_err <= 1'b1;
            if (word == WORD_LAST) begin
              state <= S_RD_GO;
            end else begin
              word    <= word + 1'b1;
              rd_next <= 1'b1;
            end
          end
        end
        S_RD_GO: begin
          // go must be seen high before a stop can release it.
          ext_read_go <= 1'b1;
          if (ext_read_go && stop_s) begin
            ext_read_go <= 1'b0;
            state       <= S_RD_REL;
          end
        end
        S_RD_REL: begin
          if (!stop_s && !act_r) state <= S_IDLE;
        end
        S_WR_FETCH: begin
          wr_first <= 1'b1;
          state    <= S_WR_REQ;
        end
        S_WR_REQ: begin
          if (xfer_done) begin
            if (xfer_error) dma_err <= 1'b1;
            if (word == WORD_LAST) begin
              ext_write_done <= 1'b1;
              state          <= S_WR_DONE;
            end else begin
              word             <= word + 1'b1;
              bram_wr_ext_addr <= word + 1'b1;
              state            <= S_WR_FETCH;
            end
          end
        end
        S_WR_DONE: begin
          if (!act_w) begin
            ext_write_done <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
